// File: rtl/accelerator_activation_unit.sv
// Fixed-point activation unit: identity / ReLU / ReLU6 / hard-swish over
// LANES parallel lanes. A capture register followed by three compute stages
// (S1 offset/clamp, S2 multiply, S3 divide/saturate) under valid/ready
// backpressure, so a beat accepted at edge N is on out_* after edge N+3.

// One lane's datapath. Stage load enables and per-stage modes come from the
// shared control in the top; lanes never talk to each other.
module accelerator_activation_lane #(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        ld,
    input  logic [1:0]        mode_cap,
    input  logic [1:0]        mode_s1,
    input  logic [1:0]        mode_s2,
    input  logic [DATA_W-1:0] x_in,
    output logic [DATA_W-1:0] y,
    output logic              sat
);
    localparam int PW = 2 * DATA_W + 1;
    localparam logic signed [DATA_W:0] THREE_E = (DATA_W+1)'(3 << FRAC_W);
    localparam logic signed [DATA_W:0] SIX_E   = (DATA_W+1)'(6 << FRAC_W);
    localparam logic signed [PW-1:0]   SIX_P   = PW'(6 << FRAC_W);
    localparam logic signed [PW-1:0]   ONE_P   = PW'(1);
    localparam logic signed [PW-1:0]   MAX_P   = {{(DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [PW-1:0]   MIN_P   = {{(DATA_W+2){1'b1}}, {(DATA_W-1){1'b0}}};

    logic signed [DATA_W-1:0] x_q, x_s1;
    logic signed [DATA_W:0]   opnd_s1;
    logic signed [PW-1:0]     prod_s2;

    logic signed [DATA_W:0]   xe, sum, clp, relu, relu6, opnd_d;
    logic signed [PW-1:0]     prod_d, q, rem, yv;
    logic [DATA_W-1:0]        y_d;
    logic                     sat_d;

    // S1: x+THREE in one extra bit so full-scale x cannot wrap negative
    always_comb begin
        xe    = {x_q[DATA_W-1], x_q};
        sum   = xe + THREE_E;
        clp   = sum[DATA_W] ? '0 : ((sum > SIX_E) ? SIX_E : sum);
        relu  = xe[DATA_W] ? '0 : xe;
        relu6 = (relu > SIX_E) ? SIX_E : relu;
        case (mode_cap)
            2'd0:    opnd_d = xe;
            2'd1:    opnd_d = relu;
            2'd2:    opnd_d = relu6;
            default: opnd_d = clp;
        endcase
    end

    // S2: only hard-swish multiplies; other modes carry their result through
    always_comb begin
        prod_d = (mode_s1 == 2'd3) ? PW'(x_s1) * PW'(opnd_s1) : PW'(opnd_s1);
    end

    // S3: floor division (truncating divide, corrected for negative remainders)
    // then saturation to the lane range
    always_comb begin
        q   = prod_s2 / SIX_P;
        rem = prod_s2 % SIX_P;
        if (mode_s2 == 2'd3)
            yv = (rem != '0 && prod_s2[PW-1]) ? q - ONE_P : q;
        else
            yv = prod_s2;
        sat_d = 1'b0;
        y_d   = yv[DATA_W-1:0];
        if (yv > MAX_P) begin
            sat_d = 1'b1;
            y_d   = MAX_P[DATA_W-1:0];
        end else if (yv < MIN_P) begin
            sat_d = 1'b1;
            y_d   = MIN_P[DATA_W-1:0];
        end
    end

    // Lane stage registers, each loaded only when its stage takes a beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q     <= '0;
            x_s1    <= '0;
            opnd_s1 <= '0;
            prod_s2 <= '0;
            y       <= '0;
            sat     <= 1'b0;
        end else begin
            if (ld[0]) x_q <= x_in;
            if (ld[1]) begin
                x_s1    <= x_q;
                opnd_s1 <= opnd_d;
            end
            if (ld[2]) prod_s2 <= prod_d;
            if (ld[3]) begin
                y   <= y_d;
                sat <= sat_d;
            end
        end
    end
endmodule

module accelerator_activation_unit #(
    parameter int LANES  = 4,
    parameter int DATA_W = 16,
    parameter int FRAC_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*DATA_W-1:0] in_data,
    input  logic [1:0]              in_mode,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*DATA_W-1:0] out_data,
    output logic                    out_last,
    output logic [LANES-1:0]        out_sat
);
    // index 0 is the capture register, 1..3 are S1..S3
    localparam int STAGES = 3;

    logic [STAGES:0]        vld_pipe;
    logic [STAGES:0]        last_pipe;
    logic [STAGES-1:0][1:0] mode_pipe;
    logic                   go_0, go_1, go_2, go_3;
    logic [3:0]             ld;
    logic [LANES-1:0][DATA_W-1:0] lane_y;

    // A stage moves when it is empty or the stage after it moves
    assign go_3     = ~vld_pipe[3] | out_ready;
    assign go_2     = ~vld_pipe[2] | go_3;
    assign go_1     = ~vld_pipe[1] | go_2;
    assign go_0     = ~vld_pipe[0] | go_1;
    assign in_ready = go_0;
    assign ld       = {go_3 & vld_pipe[2], go_2 & vld_pipe[1],
                       go_1 & vld_pipe[0], go_0 & in_valid};

    // Valid, mode and last travel alongside the lane data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe  <= '0;
            last_pipe <= '0;
            mode_pipe <= '0;
        end else begin
            if (go_0) vld_pipe[0] <= in_valid;
            if (go_1) vld_pipe[1] <= vld_pipe[0];
            if (go_2) vld_pipe[2] <= vld_pipe[1];
            if (go_3) vld_pipe[3] <= vld_pipe[2];
            if (ld[0]) begin
                last_pipe[0] <= in_last;
                mode_pipe[0] <= in_mode;
            end
            if (ld[1]) begin
                last_pipe[1] <= last_pipe[0];
                mode_pipe[1] <= mode_pipe[0];
            end
            if (ld[2]) begin
                last_pipe[2] <= last_pipe[1];
                mode_pipe[2] <= mode_pipe[1];
            end
            if (ld[3]) last_pipe[3] <= last_pipe[2];
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        accelerator_activation_lane #(.DATA_W(DATA_W), .FRAC_W(FRAC_W)) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .ld       (ld),
            .mode_cap (mode_pipe[0]),
            .mode_s1  (mode_pipe[1]),
            .mode_s2  (mode_pipe[2]),
            .x_in     (in_data[i*DATA_W +: DATA_W]),
            .y        (lane_y[i]),
            .sat      (out_sat[i])
        );
    end

    assign out_data  = lane_y;
    assign out_valid = vld_pipe[3];
    assign out_last  = last_pipe[3];
endmodule

// File: tb/tb_accelerator_activation_unit.sv
// Scoreboard bench for accelerator_activation_unit (LANES=4, DATA_W=16, FRAC_W=8).
module tb_accelerator_activation_unit;
    localparam int W = 64;
    localparam int DW = 16;
    localparam longint THREE = 3 << 8;
    localparam longint SIX   = 6 << 8;
    localparam longint MAXV  = 32767;
    localparam longint MINV  = -32768;

    logic clk = 0, rst_n = 0, in_valid = 0, in_last = 0, out_ready = 1;
    logic in_ready, out_valid, out_last;
    logic [W-1:0] in_data = '0, out_data;
    logic [1:0]   in_mode = '0;
    logic [3:0]   out_sat;

    accelerator_activation_unit #(.LANES(4), .DATA_W(16), .FRAC_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_mode(in_mode), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .out_sat(out_sat)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] d;
        logic         l;
        logic [3:0]   s;
        int           c;
    } exp_t;
    exp_t sb[$];

    int checks = 0, failures = 0;
    bit free_run = 1, rdy_rand = 0;

    task automatic chk(input string name, input bit ok, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: the arithmetic rules written with wide integers
    function automatic void model(input logic [W-1:0] d, input logic [1:0] m,
                                  output logic [W-1:0] y, output logic [3:0] s);
        for (int i = 0; i < 4; i++) begin
            longint x, r, c, p;
            logic [15:0] xs;
            xs = d[i*DW +: DW];
            x  = longint'(signed'(xs));
            s[i] = 1'b0;
            case (m)
                2'd0: r = x;
                2'd1: r = (x > 0) ? x : 0;
                2'd2: r = (x < 0) ? 0 : ((x > SIX) ? SIX : x);
                default: begin
                    c = x + THREE;
                    if (c < 0) c = 0;
                    if (c > SIX) c = SIX;
                    p = x * c;
                    r = p / SIX;
                    if ((p % SIX) != 0 && p < 0) r = r - 1;
                end
            endcase
            if (r > MAXV) begin r = MAXV; s[i] = 1'b1; end
            if (r < MINV) begin r = MINV; s[i] = 1'b1; end
            y[i*DW +: DW] = r[15:0];
        end
    endfunction

    function automatic logic [W-1:0] pk(input int a, input int b, input int c, input int d);
        return {d[15:0], c[15:0], b[15:0], a[15:0]};
    endfunction

    function automatic logic [15:0] rnd16();
        logic [31:0] t;
        t = $urandom();
        case (t[3:0])
            4'd0: return 16'h7fff;
            4'd1: return 16'h8000;
            4'd2: return 16'(SIX);
            4'd3: return 16'(-THREE);
            4'd4: return 16'(-THREE - 1);
            default: return t[31:16];
        endcase
    endfunction

    task automatic send(input logic [W-1:0] d, input logic [1:0] m, input logic l,
                        input logic [W-1:0] ed, input logic [3:0] es);
        int n = 0;
        exp_t e;
        in_data = d; in_mode = m; in_last = l; in_valid = 1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 200) begin
                chk("accept_timeout", 0, 64'(n), 64'(200));
                in_valid = 0;
                return;
            end
        end
        e.d = ed; e.l = l; e.s = es; e.c = cyc + 1;
        sb.push_back(e);
        @(posedge clk); #1;
        in_valid = 0;
    endtask

    task automatic send_model(input logic [W-1:0] d, input logic [1:0] m, input logic l);
        logic [W-1:0] y;
        logic [3:0]   s;
        model(d, m, y, s);
        send(d, m, l, y, s);
    endtask

    task automatic send_rand(input logic l);
        send_model({rnd16(), rnd16(), rnd16(), rnd16()}, 2'($urandom_range(0, 3)), l);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        chk("drain", sb.size() == 0, 64'(sb.size()), 64'(0));
        repeat (4) @(posedge clk);
        #1;
    endtask

    // Backpressure generator
    initial forever begin
        @(posedge clk); #1;
        out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: pops the scoreboard on each output transfer and checks that a
    // stalled output does not move
    initial begin : mon
        exp_t e;
        int lat;
        logic stalled = 0;
        logic [W-1:0] hd = '0;
        logic hl = 0;
        logic [3:0] hs = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stalled = 0;
                continue;
            end
            if (stalled) begin
                chk("stall_valid", out_valid == 1'b1, 64'(out_valid), 64'(1));
                chk("stall_hold", out_data == hd && out_last == hl && out_sat == hs, out_data, hd);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_beat", 0, out_data, '0);
                end else begin
                    e = sb.pop_front();
                    chk("data", out_data == e.d, out_data, e.d);
                    chk("last", out_last == e.l, 64'(out_last), 64'(e.l));
                    chk("sat", out_sat == e.s, 64'(out_sat), 64'(e.s));
                    lat = cyc - e.c;
                    if (free_run) chk("latency", lat == 3, 64'(lat), 64'(3));
                    else          chk("latency_min", lat >= 3, 64'(lat), 64'(3));
                end
            end
            stalled = out_valid && !out_ready;
            hd = out_data; hl = out_last; hs = out_sat;
        end
    end

    initial begin
        #500000;
        chk("global_timeout", 0, '0, 64'(1));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int c0;
        rst_n = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid == 1'b0, 64'(out_valid), 64'(0));
        chk("rst_out_data", out_data == '0, out_data, '0);
        chk("rst_out_last", out_last == 1'b0, 64'(out_last), 64'(0));
        chk("rst_out_sat", out_sat == '0, 64'(out_sat), 64'(0));
        @(posedge clk); #1;
        rst_n = 1;
        #1;
        chk("rst_in_ready", in_ready == 1'b1, 64'(in_ready), 64'(1));

        // Directed beats, the first one on the first edge after release
        send(pk(256, -256, 1024, -1024), 2'd3, 0, pk(170, -86, 1024, 0), 4'h0);
        send(pk(1792, -5, 100, 1536), 2'd2, 0, pk(1536, 0, 100, 1536), 4'h0);
        send(pk(1792, -5, 100, 1536), 2'd1, 0, pk(1792, 0, 100, 1536), 4'h0);
        // full-scale hard-swish: c clamps to SIX, so x*SIX/SIX lands exactly on the rail
        send(pk(32767, -32768, 0, 1), 2'd3, 0, pk(32767, 0, 0, 0), 4'h0);
        send(pk(32767, -32768, 0, 1), 2'd0, 0, pk(32767, -32768, 0, 1), 4'h0);
        send(pk(256, 256, 256, 256), 2'd0, 0, pk(256, 256, 256, 256), 4'h0);
        send(pk(256, 256, 256, 256), 2'd3, 0, pk(170, 170, 170, 170), 4'h0);
        send(pk(256, 256, 256, 256), 2'd1, 0, pk(256, 256, 256, 256), 4'h0);
        send(pk(256, 256, 256, 256), 2'd2, 0, pk(256, 256, 256, 256), 4'h0);
        drain();

        // Full throughput with out_ready held high
        c0 = cyc;
        for (int i = 0; i < 20; i++) send_rand(i == 19);
        chk("throughput", (cyc - c0) == 20, 64'(cyc - c0), 64'(20));
        drain();

        // Ten back-to-back beats under random backpressure, last on the tenth
        free_run = 0;
        rdy_rand = 1;
        for (int i = 0; i < 10; i++) send_rand(i == 9);
        drain();

        // Random traffic with input gaps and backpressure
        for (int i = 0; i < 150; i++) begin
            send_rand(1'($urandom_range(0, 7) == 0));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        drain();
        rdy_rand = 0;
        @(posedge clk); #2;
        free_run = 1;

        // Reset with three beats in flight: nothing stale may come out
        for (int i = 0; i < 3; i++) send_rand(0);
        rst_n = 0;
        #1;
        chk("midrst_out_valid", out_valid == 1'b0, 64'(out_valid), 64'(0));
        chk("midrst_out_data", out_data == '0, out_data, '0);
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1;
        send(pk(256, -256, 1024, -1024), 2'd3, 1, pk(170, -86, 1024, 0), 4'h0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
